// File: rtl/uart_rx_core.sv
// uart_rx_core: 8-bit UART receiver with 16x oversampling.
//
// Frame: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
// The serial input is synchronised with a 2-FF synchroniser. A frame starts
// on a 1->0 transition of the synchronised line seen in IDLE. Every bit is
// sampled at its middle, which is 8 ticks after the start edge plus a whole
// number of 16-tick bit periods.
//
// rst_n is asserted asynchronously. Its release is expected to be
// synchronous to clk.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   data_rx      in   serial input, idle high, asynchronous to clk
//   baud_rate    in   00=2400 01=4800 10=9600 11=19200, latched at start edge
//   parity_type  in   00=none 01=odd 10=even 11=none, latched at start edge
//   data_out     out  last received byte
//   data_valid   out  1-clk pulse: data_out / parity_error / frame_error updated
//   parity_error out  parity mismatch on last frame (held until next data_valid)
//   frame_error  out  stop bit sampled low on last frame (held likewise)
//   active_flag  out  high from start edge until the stop-bit sample
//   done_flag    out  1-clk pulse, same cycle as data_valid
//
// Handshake: data_valid is a single-cycle strobe with no ready/back-pressure.
// data_out and both error flags are stable from the data_valid cycle until
// the next data_valid.
module uart_rx_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       active_flag,
  output logic       done_flag
);

  localparam int DIV_2400  = CLK_HZ / (2400  * OVERSAMPLE);
  localparam int DIV_4800  = CLK_HZ / (4800  * OVERSAMPLE);
  localparam int DIV_9600  = CLK_HZ / (9600  * OVERSAMPLE);
  localparam int DIV_19200 = CLK_HZ / (19200 * OVERSAMPLE);
  localparam int CNT_W     = (DIV_2400 > 1) ? $clog2(DIV_2400) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;
  logic [1:0]       baud_q, baud_d;
  logic [1:0]       par_q, par_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_pend_q, par_pend_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             parity_error_q, parity_error_d;
  logic             frame_error_q, frame_error_d;
  logic             active_q, active_d;

  logic [CNT_W-1:0] div_m1;
  logic             tick;
  logic             start_edge;
  logic             mid_sample;
  logic             bit_sample;
  logic             parity_en;
  logic             exp_par;

  // Tick divider terminal count for the latched baud rate.
  always_comb begin
    div_m1 = CNT_W'(DIV_9600 - 1);
    case (baud_q)
      2'b00:   div_m1 = CNT_W'(DIV_2400 - 1);
      2'b01:   div_m1 = CNT_W'(DIV_4800 - 1);
      2'b10:   div_m1 = CNT_W'(DIV_9600 - 1);
      default: div_m1 = CNT_W'(DIV_19200 - 1);
    endcase
  end

  // The synchroniser flops reset high, so the first two synchronised samples
  // after reset do not come from the pin. fill_q marks when rx_s_q is real,
  // and armed_q requires one real high sample before any start edge is
  // accepted; a line held low through reset therefore never starts a frame.
  always_comb begin
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & rx_s_q);
  end

  assign tick       = (div_cnt_q == div_m1);
  assign start_edge = (state_q == S_IDLE) && armed_q && rx_prev_q && !rx_s_q;
  assign mid_sample = tick && (tick_cnt_q == 4'd7);
  assign bit_sample = tick && (tick_cnt_q == 4'd15);
  assign parity_en  = (par_q == 2'b01) || (par_q == 2'b10);
  assign exp_par    = (par_q == 2'b10) ? ^shift_q : ~^shift_q;

  // Divider restarts on the start edge so tick phase is locked to the edge.
  always_comb begin
    div_cnt_d = div_cnt_q + CNT_W'(1);
    if (start_edge || tick) div_cnt_d = '0;
  end

  // State register and all other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_prev_q      <= 1'b1;
      fill_q         <= 2'b00;
      armed_q        <= 1'b0;
      baud_q         <= 2'b00;
      par_q          <= 2'b00;
      div_cnt_q      <= '0;
      tick_cnt_q     <= 4'd0;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      par_pend_q     <= 1'b0;
      data_out_q     <= 8'h00;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_meta_q      <= data_rx;
      rx_s_q         <= rx_meta_q;
      rx_prev_q      <= rx_s_q;
      fill_q         <= fill_d;
      armed_q        <= armed_d;
      baud_q         <= baud_d;
      par_q          <= par_d;
      div_cnt_q      <= div_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_pend_q     <= par_pend_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      active_q       <= active_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_edge) state_d = S_START;
      S_START:     if (mid_sample) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:      if (bit_sample && (bit_cnt_q == 3'd7))
                     state_d = parity_en ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_sample) state_d = S_STOP;
      S_STOP:      if (bit_sample) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_comb begin
    baud_d         = baud_q;
    par_d          = par_q;
    tick_cnt_d     = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_pend_d     = par_pend_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    active_d       = active_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          baud_d     = baud_rate;
          par_d      = parity_type;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
          par_pend_d = 1'b0;
          active_d   = 1'b1;
        end
      end
      S_START: begin
        if (mid_sample) begin
          // Re-zero so the data bits are sampled 16 ticks apart from here.
          tick_cnt_d = 4'd0;
          if (rx_s_q) active_d = 1'b0;
        end
      end
      S_DATA: begin
        if (bit_sample) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (bit_sample && (rx_s_q != exp_par)) par_pend_d = 1'b1;
      end
      S_STOP: begin
        if (bit_sample) begin
          data_out_d     = shift_q;
          parity_error_d = par_pend_q;
          frame_error_d  = !rx_s_q;
          data_valid_d   = 1'b1;
          active_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign done_flag    = data_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign active_flag  = active_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core at CLK_HZ=1_228_800 (9600 baud -> 128 clk/bit).
module tb_uart_rx_core;

  localparam int CLK_HZ = 1_228_800;

  logic       clk;
  logic       rst_n;
  logic       data_rx;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       active_flag;
  logic       done_flag;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_rx      (data_rx),
    .baud_rate    (baud_rate),
    .parity_type  (parity_type),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .active_flag  (active_flag),
    .done_flag    (done_flag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];   // {frame_error, parity_error, data}
  int unsigned dv_cyc_last, dv_cyc_prev;
  logic dv_seen_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dv_seen_prev) chk("dv_pulse_width", {31'd0, data_valid}, 0);
      if (data_valid || done_flag) begin
        chk("data_valid", {31'd0, data_valid}, 1);
        chk("done_flag", {31'd0, done_flag}, 1);
      end
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_data_valid: got data_out 0x%0h expected no frame", data_out);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
          chk("parity_error", {31'd0, parity_error}, {31'd0, e[8]});
          chk("frame_error", {31'd0, frame_error}, {31'd0, e[9]});
          chk("active_at_dv", {31'd0, active_flag}, 0);
        end
        dv_cyc_prev = dv_cyc_last;
        dv_cyc_last = cyc;
      end
      dv_seen_prev = data_valid;
    end else begin
      dv_seen_prev = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic model_par_bit(input logic [7:0] d, input logic [1:0] pt);
    int ones;
    ones = $countones(d);
    if (pt == 2'b10) return logic'(ones % 2);       // even: total ones even
    return logic'(1 - (ones % 2));                   // odd: total ones odd
  endfunction

  function automatic bit model_par_en(input logic [1:0] pt);
    return (pt == 2'b01) || (pt == 2'b10);
  endfunction

  function automatic int clk_per_bit(input logic [1:0] b);
    return CLK_HZ / (2400 << b);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // chg_bit >= 0 switches baud_rate to 2400 while that bit is on the line.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt,
                            input logic par_bit, input logic stop,
                            input int cpb, input int chg_bit);
    logic b[$];
    parity_type = pt;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (model_par_en(pt)) b.push_back(par_bit);
    b.push_back(stop);
    foreach (b[i]) begin
      if (i == chg_bit) baud_rate = 2'b00;
      data_rx = b[i];
      wait_clk(cpb);
    end
    if (!stop) wait_clk(500);
    data_rx = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
    exp_q.push_back({ferr, perr, d});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) wait_clk(1);
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic [1:0] pt;
    logic       par_bit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 2'b10, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 2'b10, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{8'h01, 2'b01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 2'b01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h55, 2'b00, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    tbl[6] = '{8'h12, 2'b00, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
    tbl[7] = '{8'h5A, 2'b11, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

    rst_n        = 1'b0;
    data_rx      = 1'b0;
    baud_rate    = 2'b10;
    parity_type  = 2'b00;
    dv_cyc_last  = 0;
    dv_cyc_prev  = 0;
    dv_seen_prev = 1'b0;

    // Reset state, with the line held low through reset.
    wait_clk(3);
    chk("rst_data_out", {24'd0, data_out}, 0);
    chk("rst_outputs", {27'd0, data_valid, parity_error, frame_error, active_flag, done_flag}, 0);
    rst_n = 1'b1;
    wait_clk(100);
    chk("low_after_reset_active", {31'd0, active_flag}, 0);
    wait_clk(1400);
    chk("low_after_reset_active_late", {31'd0, active_flag}, 0);
    data_rx = 1'b1;
    wait_clk(50);

    // Table-driven frames at 9600.
    for (int i = 0; i < 8; i++) begin
      expect_frame(tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr);
      send_frame(tbl[i].data, tbl[i].pt, tbl[i].par_bit, tbl[i].stop, 128, -1);
      wait_clk(50);
      wait_drain("table_drain");
      wait_clk(150);
      chk("held_parity_error", {31'd0, parity_error}, {31'd0, tbl[i].exp_perr});
      chk("held_frame_error", {31'd0, frame_error}, {31'd0, tbl[i].exp_ferr});
    end

    // Back-to-back 0x00 then 0xFF, no idle gap, no parity.
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 2'b00, 1'b0, 1'b1, 128, -1);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 128, -1);
    wait_clk(50);
    wait_drain("b2b_drain");
    chk("b2b_spacing", dv_cyc_last - dv_cyc_prev, 1280);

    // Short low glitch on an idle line.
    data_rx = 1'b0;
    wait_clk(20);
    chk("glitch_active_high", {31'd0, active_flag}, 1);
    wait_clk(20);
    data_rx = 1'b1;
    wait_clk(60);
    chk("glitch_active_low", {31'd0, active_flag}, 0);
    wait_clk(1500);

    // Reset mid-DATA, then a clean frame.
    data_rx = 1'b0;
    wait_clk(128 * 3);
    chk("midframe_active", {31'd0, active_flag}, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", {24'd0, data_out}, 0);
    chk("midrst_outputs", {27'd0, data_valid, parity_error, frame_error, active_flag, done_flag}, 0);
    wait_clk(5);
    data_rx = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(50);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 2'b00, 1'b0, 1'b1, 128, -1);
    wait_clk(50);
    wait_drain("after_reset_drain");

    // Baud change mid-frame: current frame at 9600, next at 2400.
    baud_rate = 2'b10;
    expect_frame(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 2'b00, 1'b0, 1'b1, 128, 4);
    wait_clk(50);
    wait_drain("baud_chg_drain");
    expect_frame(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b1, clk_per_bit(2'b00), -1);
    wait_clk(50);
    wait_drain("slow_frame_drain");

    // Random frames against the model.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic [1:0] pt;
      logic [1:0] br;
      logic       pb;
      logic       flip;
      d    = 8'($urandom);
      pt   = 2'($urandom_range(0, 3));
      br   = 2'($urandom_range(2, 3));
      flip = 1'($urandom_range(0, 1));
      pb   = model_par_bit(d, pt) ^ flip;
      baud_rate = br;
      expect_frame(d, logic'(model_par_en(pt) && (pb != model_par_bit(d, pt))), 1'b0);
      send_frame(d, pt, pb, 1'b1, clk_per_bit(br), -1);
      wait_clk($urandom_range(0, 20));
    end
    wait_clk(50);
    wait_drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
